uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (tx_start / din / tx_done_tick handshake) among N_REQ byte producers.
- Round-robin arbitration at byte granularity, with packet lock via req_last: a requester keeps the grant until its last byte is sent.
- Sequences each byte: load, start pulse, wait for done.
- Watchdog aborts a byte whose tx_done_tick never arrives.
- Sits between the command/telemetry sources and the transmitter FSM.

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester byte bus plus transmitter start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_last;
    logic [N_REQ-1:0]    req_ready;
    logic                tx_start;
    logic [DW-1:0]       tx_din;
    logic                tx_done_tick;

    // Environment side: byte producers and the transmitter FSM
    modport master (
        output req_valid, req_data, req_last, tx_done_tick,
        input  req_ready, tx_start, tx_din
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done_tick,
        output req_ready, tx_start, tx_din
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, packet-locking arbiter feeding one UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int TO_CYCLES = 200000
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_tx_arbiter_if.slave         bus,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     locked,
    output logic                     timeout_err
);
    localparam int c_idw = $clog2(N_REQ);
    localparam int c_cw  = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [DW-1:0]    r_tx_din;
    logic [c_idw-1:0] r_grant_id;
    logic [c_idw-1:0] r_rr_ptr;
    logic             r_locked;
    logic [c_cw-1:0]  r_wd_cnt;

    logic             w_found;
    logic [c_idw-1:0] w_winner;
    logic             w_wd_expire;
    logic             w_tx_start;
    logic [N_REQ-1:0] w_req_ready;
    logic             w_busy;
    logic             w_timeout;

    function automatic logic [c_idw-1:0] rr_index(input logic [c_idw-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % N_REQ;
        return c_idw'(s);
    endfunction

    // While locked only the owner (last grantee) may win
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        if (r_locked) begin
            w_found  = bus.req_valid[r_grant_id];
            w_winner = r_grant_id;
        end else begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!w_found && bus.req_valid[rr_index(r_rr_ptr, j)]) begin
                    w_found  = 1'b1;
                    w_winner = rr_index(r_rr_ptr, j);
                end
            end
        end
    end

    generate
        if (TO_CYCLES != 0) begin : g_wd_on
            localparam logic [c_cw-1:0] c_to_last = c_cw'(TO_CYCLES - 1);
            assign w_wd_expire = (r_wd_cnt == c_to_last);
        end else begin : g_wd_off
            assign w_wd_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_found) w_next_state = c_start;
            c_start: w_next_state = c_wait;
            c_wait:  if (bus.tx_done_tick || w_wd_expire) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        w_tx_start  = 1'b0;
        w_req_ready = '0;
        w_busy      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_start: begin
                w_tx_start  = 1'b1;
                w_req_ready = N_REQ'(1) << r_grant_id;
                w_busy      = 1'b1;
            end
            c_wait: begin
                w_busy    = 1'b1;
                // A done arriving on the expiry cycle wins over the abort
                w_timeout = w_wd_expire && !bus.tx_done_tick;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_din   <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_locked   <= 1'b0;
            r_wd_cnt   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_found) begin
                        r_tx_din   <= bus.req_data[int'(w_winner)*DW +: DW];
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= rr_index(w_winner, 1);
                        r_locked   <= ~bus.req_last[w_winner];
                    end
                end
                c_start: r_wd_cnt <= '0;
                c_wait: begin
                    if (r_wd_cnt != '1) r_wd_cnt <= r_wd_cnt + 1'b1;
                    if (w_timeout) r_locked <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_start  = w_tx_start;
    assign bus.req_ready = w_req_ready;
    assign bus.tx_din    = r_tx_din;
    assign grant_id      = r_grant_id;
    assign busy          = w_busy;
    assign locked        = r_locked;
    assign timeout_err   = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant_id;
    logic       busy;
    logic       locked;
    logic       timeout_err;
    int         errors = 0;
    int         checks = 0;

    uart_tx_arbiter_if #(.N_REQ(4), .DW(8)) bus ();

    uart_tx_arbiter #(.N_REQ(4), .DW(8), .TO_CYCLES(50)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte: START checks, valid update, WAIT, done pulse, back in IDLE
    task automatic do_byte(input int id, input logic [7:0] d, input logic lk,
                           input int waits, input logic [3:0] nv);
        step();
        chk("start", 32'(bus.tx_start), 32'd1);
        chk("ready", 32'(bus.req_ready), 32'(4'b0001 << id));
        chk("din", 32'(bus.tx_din), 32'(d));
        chk("grant", 32'(grant_id), 32'(id));
        chk("locked", 32'(locked), 32'(lk));
        bus.req_valid = nv;
        step();
        chk("ready_1cyc", 32'(bus.req_ready), 32'd0);
        chk("start_1cyc", 32'(bus.tx_start), 32'd0);
        repeat (waits) step();
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.req_last     = '0;
        bus.tx_done_tick = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(bus.tx_start), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_din", 32'(bus.tx_din), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        reset = 1'b0;

        // Single byte from requester 2
        bus.req_valid = 4'b0100;
        bus.req_data[23:16] = 8'hA5;
        bus.req_last = 4'b0100;
        do_byte(2, 8'hA5, 1'b0, 18, 4'b0000);
        chk("single_locked", 32'(locked), 32'd0);
        chk("din_hold", 32'(bus.tx_din), 32'hA5);

        // Round robin from a fresh pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.req_data = 32'h13121110;
        bus.req_last = 4'b1111;
        bus.req_valid = 4'b1111;
        do_byte(0, 8'h10, 1'b0, 3, 4'b1111);
        do_byte(1, 8'h11, 1'b0, 3, 4'b1111);
        do_byte(2, 8'h12, 1'b0, 3, 4'b1111);
        do_byte(3, 8'h13, 1'b0, 3, 4'b1111);
        do_byte(0, 8'h10, 1'b0, 3, 4'b0000);

        // Packet lock on requester 1 while 0 and 2 wait
        bus.req_data = 32'h00D2B0D0;
        bus.req_last = 4'b0101;
        bus.req_valid = 4'b0111;
        do_byte(1, 8'hB0, 1'b1, 3, 4'b0111);
        bus.req_data[15:8] = 8'hB1;
        do_byte(1, 8'hB1, 1'b1, 3, 4'b0111);
        bus.req_data[15:8] = 8'hB2;
        bus.req_last = 4'b0111;
        do_byte(1, 8'hB2, 1'b0, 3, 4'b0101);
        do_byte(2, 8'hD2, 1'b0, 3, 4'b0001);
        do_byte(0, 8'hD0, 1'b0, 3, 4'b0000);

        // Watchdog abort while locked to requester 1
        bus.req_data = 32'hC300C100;
        bus.req_last = 4'b1000;
        bus.req_valid = 4'b1010;
        step();
        chk("wd_grant", 32'(grant_id), 32'd1);
        chk("wd_locked", 32'(locked), 32'd1);
        bus.req_valid = 4'b1000;
        step();
        repeat (48) step();
        chk("wd_c49_tmo", 32'(timeout_err), 32'd0);
        step();
        chk("wd_c50_tmo", 32'(timeout_err), 32'd1);
        chk("wd_c50_busy", 32'(busy), 32'd1);
        step();
        chk("wd_idle_tmo", 32'(timeout_err), 32'd0);
        chk("wd_unlock", 32'(locked), 32'd0);
        chk("wd_idle_busy", 32'(busy), 32'd0);
        step();
        chk("wd_next_grant", 32'(grant_id), 32'd3);
        chk("wd_next_din", 32'(bus.tx_din), 32'hC3);
        bus.req_valid = 4'b0000;
        step();
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;

        // Done during START is ignored
        bus.req_data = 32'h0000005A;
        bus.req_last = 4'b1111;
        bus.req_valid = 4'b0001;
        step();
        chk("ds_grant", 32'(grant_id), 32'd0);
        bus.req_valid = 4'b0000;
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        chk("ds_wait_busy", 32'(busy), 32'd1);
        step();
        chk("ds_wait_busy2", 32'(busy), 32'd1);
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        chk("ds_idle", 32'(busy), 32'd0);

        // Done coincident with expiry: no error, lock kept
        bus.req_data = 32'h00007700;
        bus.req_last = 4'b0000;
        bus.req_valid = 4'b0010;
        step();
        chk("co_grant", 32'(grant_id), 32'd1);
        bus.req_valid = 4'b0000;
        step();
        repeat (49) step();
        chk("co_tmo_alone", 32'(timeout_err), 32'd1);
        bus.tx_done_tick = 1'b1;
        #1;
        chk("co_tmo_masked", 32'(timeout_err), 32'd0);
        step();
        bus.tx_done_tick = 1'b0;
        chk("co_idle", 32'(busy), 32'd0);
        chk("co_locked", 32'(locked), 32'd1);

        // Reset mid-WAIT while locked
        bus.req_data = 32'h00008800;
        bus.req_valid = 4'b0010;
        step();
        chk("rw_locked", 32'(locked), 32'd1);
        bus.req_valid = 4'b0000;
        step();
        repeat (3) step();
        reset = 1'b1;
        #1;
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_locked0", 32'(locked), 32'd0);
        chk("rw_grant", 32'(grant_id), 32'd0);
        chk("rw_din", 32'(bus.tx_din), 32'd0);
        step();
        reset = 1'b0;
        bus.req_data = 32'hE30000E0;
        bus.req_last = 4'b1111;
        bus.req_valid = 4'b1001;
        step();
        chk("rw_first_grant", 32'(grant_id), 32'd0);
        chk("rw_first_din", 32'(bus.tx_din), 32'hE0);
        bus.req_valid = 4'b0000;
        step();
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        chk("rw_end", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
